pac_motion_ctrl: RTL and testbench



---
 rtl/pac_motion_ctrl_pkg.sv | 35 +++
 rtl/pac_motion_ctrl_corner_gen.sv | 54 +++++
 rtl/pac_motion_ctrl.sv | 160 ++++++++++++++++
 tb/tb_pac_motion_ctrl.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pac_motion_ctrl_pkg.sv
// Shared game constants, direction codes and FSM states for Pac-Man motion.
// Also imported by the renderer so screen/grid geometry stays in one place.
package pac_motion_ctrl_pkg;

   localparam logic [1:0] DIR_DOWN  = 2'b00;
   localparam logic [1:0] DIR_UP    = 2'b01;
   localparam logic [1:0] DIR_RIGHT = 2'b10;
   localparam logic [1:0] DIR_LEFT  = 2'b11;

   localparam int SCREEN_W  = 640;
   localparam int SCREEN_H  = 480;
   localparam int SPRITE    = 32;
   localparam int CELL      = 16;
   localparam int GRID_COLS = 40;
   localparam int GRID_ROWS = 30;
   localparam int NUM_BEANS = GRID_COLS * GRID_ROWS;

   typedef enum logic [2:0] {
      IDLE,
      PRQ_A,
      PRQ_B,
      PCU_A,
      PCU_B,
      MOVE,
      EAT
   } fsm_t;

   function automatic logic [10:0] abs_diff(
      input logic [10:0] a,
      input logic [10:0] b
   );
      return (a > b) ? a - b : b - a;
   endfunction

endpackage

// File: rtl/pac_motion_ctrl_corner_gen.sv
// pac_corner_gen: combinational probe-corner generator for one step.
// Ports: x,y,dir,step,sel in; probe_x,probe_y,out_of_range out.
module pac_corner_gen
   import pac_motion_ctrl_pkg::*;
(
   input  logic [9:0] x,
   input  logic [8:0] y,
   input  logic [1:0] dir,
   input  logic [3:0] step,
   input  logic       sel,
   output logic [9:0] probe_x,
   output logic [8:0] probe_y,
   output logic       out_of_range
);

   localparam logic signed [10:0] EDGE  = 11'(SPRITE - 1);
   localparam logic signed [10:0] X_MAX = 11'(SCREEN_W - 1);
   localparam logic signed [10:0] Y_MAX = 11'(SCREEN_H - 1);

   logic signed [10:0] sx, sy, st, off, cx, cy;

   always_comb begin
      sx  = signed'({1'b0, x});
      sy  = signed'({2'b00, y});
      st  = signed'({7'd0, step});
      // sel picks the far corner along the axis perpendicular to motion
      off = sel ? EDGE : 11'sd0;
      cx  = sx;
      cy  = sy;
      unique case (dir)
         DIR_RIGHT: begin
            cx = sx + st + EDGE;
            cy = sy + off;
         end
         DIR_LEFT: begin
            cx = sx - st;
            cy = sy + off;
         end
         DIR_DOWN: begin
            cx = sx + off;
            cy = sy + st + EDGE;
         end
         DIR_UP: begin
            cx = sx + off;
            cy = sy - st;
         end
      endcase
      out_of_range = (cx < 11'sd0) || (cx > X_MAX) ||
                     (cy < 11'sd0) || (cy > Y_MAX);
      probe_x = cx[9:0];
      probe_y = cy[8:0];
   end

endmodule

// File: rtl/pac_motion_ctrl.sv
// pac_motion_ctrl: Pac-Man position/facing/bean/score/game-over writer.
// In: clk,rst,move_tick,dir_valid,dir_req,probe_wall,ghosts. Out: probe,
// pac_x/y,state,beanmap,score,over,busy.
module pac_motion_ctrl
   import pac_motion_ctrl_pkg::*;
#(
   parameter int               STEP       = 2,
   parameter int               START_X    = 304,
   parameter int               START_Y    = 224,
   parameter logic [1199:0]    INIT_BEANS = {1200{1'b1}},
   parameter int               HIT_DIST   = 24
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          move_tick,
   input  logic          dir_valid,
   input  logic [1:0]    dir_req,
   input  logic          probe_wall,
   input  logic [9:0]    ghost1x,
   input  logic [9:0]    ghost2x,
   input  logic [9:0]    ghost3x,
   input  logic [9:0]    ghost4x,
   input  logic [8:0]    ghost1y,
   input  logic [8:0]    ghost2y,
   input  logic [8:0]    ghost3y,
   input  logic [8:0]    ghost4y,
   output logic [9:0]    probe_x,
   output logic [8:0]    probe_y,
   output logic [9:0]    pac_x,
   output logic [8:0]    pac_y,
   output logic [1:0]    state,
   output logic [1199:0] beanmap,
   output logic [10:0]   score,
   output logic          over,
   output logic          busy
);

   localparam logic [3:0]  STEP_W = 4'(STEP);
   localparam logic [9:0]  STEP_X = 10'(STEP);
   localparam logic [8:0]  STEP_Y = 9'(STEP);
   localparam logic [10:0] HIT_W  = 11'(HIT_DIST);

   fsm_t        fsm, nxt;
   logic [1:0]  pending, req, mv_dir, probe_dir;
   logic        blk_a, blk_now, eat_done, probing, corner_b;
   logic [9:0]  cx;
   logic [8:0]  cy;
   logic        oor;
   logic [4:0]  row;
   logic [5:0]  col;
   logic [10:0] idx;
   logic        bean_hit, hit;
   logic [9:0]  gx [4];
   logic [8:0]  gy [4];

   assign busy     = (fsm != IDLE);
   assign probing  = (fsm == PRQ_A) || (fsm == PRQ_B) ||
                     (fsm == PCU_A) || (fsm == PCU_B);
   assign corner_b = (fsm == PRQ_B) || (fsm == PCU_B);
   assign probe_dir = ((fsm == PCU_A) || (fsm == PCU_B)) ? state : req;

   pac_corner_gen u_corner (
      .x            (pac_x),
      .y            (pac_y),
      .dir          (probe_dir),
      .step         (STEP_W),
      .sel          (corner_b),
      .probe_x      (cx),
      .probe_y      (cy),
      .out_of_range (oor)
   );

   // off-screen corners never reach the wall map
   assign blk_now = oor | probe_wall;
   assign probe_x = probing ? cx : '0;
   assign probe_y = probing ? cy : '0;

   // cell under the sprite centre
   assign row = 5'(({1'b0, pac_y} + 10'd16) >> 4);
   assign col = 6'(({1'b0, pac_x} + 11'd16) >> 4);
   assign idx = 11'(row) * 11'(GRID_COLS) + 11'(col);
   assign bean_hit = (idx < 11'(NUM_BEANS)) && beanmap[idx];

   assign gx = '{ghost1x, ghost2x, ghost3x, ghost4x};
   assign gy = '{ghost1y, ghost2y, ghost3y, ghost4y};

   always_comb begin
      hit = 1'b0;
      for (int i = 0; i < 4; i++) begin
         if (abs_diff(11'(pac_x), 11'(gx[i])) < HIT_W &&
             abs_diff(11'(pac_y), 11'(gy[i])) < HIT_W)
            hit = 1'b1;
      end
   end

   always_comb begin
      nxt = fsm;
      unique case (fsm)
         IDLE:  if (move_tick && !over) nxt = PRQ_A;
         PRQ_A: nxt = PRQ_B;
         PRQ_B: begin
            if (!(blk_a || blk_now)) nxt = MOVE;
            // fallback would re-test the same direction
            else if (req == state)   nxt = IDLE;
            else                     nxt = PCU_A;
         end
         PCU_A: nxt = PCU_B;
         PCU_B: nxt = (blk_a || blk_now) ? IDLE : MOVE;
         MOVE:  nxt = EAT;
         EAT:   nxt = IDLE;
         default: nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         fsm      <= IDLE;
         pending  <= DIR_RIGHT;
         req      <= DIR_RIGHT;
         mv_dir   <= DIR_RIGHT;
         blk_a    <= 1'b0;
         eat_done <= 1'b0;
         pac_x    <= 10'(START_X);
         pac_y    <= 9'(START_Y);
         state    <= DIR_RIGHT;
         beanmap  <= INIT_BEANS;
         score    <= '0;
         over     <= 1'b0;
      end else begin
         fsm      <= nxt;
         eat_done <= (fsm == EAT);
         if (dir_valid) pending <= dir_req;
         if (hit || (eat_done && beanmap == '0)) over <= 1'b1;
         unique case (fsm)
            // snapshot so mid-probe requests wait for the next tick
            IDLE:         req   <= pending;
            PRQ_A, PCU_A: blk_a <= blk_now;
            PRQ_B:        mv_dir <= req;
            PCU_B:        mv_dir <= state;
            MOVE: begin
               state <= mv_dir;
               unique case (mv_dir)
                  DIR_RIGHT: pac_x <= pac_x + STEP_X;
                  DIR_LEFT:  pac_x <= pac_x - STEP_X;
                  DIR_DOWN:  pac_y <= pac_y + STEP_Y;
                  DIR_UP:    pac_y <= pac_y - STEP_Y;
               endcase
            end
            EAT: begin
               if (bean_hit) begin
                  beanmap[idx] <= 1'b0;
                  score        <= score + 11'd1;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_pac_motion_ctrl.sv
// Self-checking bench for pac_motion_ctrl with a move scoreboard.
// Second instance covers the last-bean game-over path.
module tb_pac_motion_ctrl;

   logic          clk = 1'b0;
   logic          rst;
   logic          move_tick, dir_valid, wall_mode;
   logic [1:0]    dir_req;
   logic          probe_wall;
   logic [9:0]    g1x, g2x, g3x, g4x;
   logic [8:0]    g1y, g2y, g3y, g4y;
   logic [9:0]    probe_x, pac_x;
   logic [8:0]    probe_y, pac_y;
   logic [1:0]    state;
   logic [1199:0] beanmap;
   logic [10:0]   score;
   logic          over, busy;

   logic          tick2, zero;
   logic [9:0]    probe_x2, pac_x2;
   logic [8:0]    probe_y2, pac_y2;
   logic [1:0]    state2;
   logic [1199:0] beanmap2;
   logic [10:0]   score2;
   logic          over2, busy2;

   localparam logic [1199:0] ONE_BEAN = 1200'd1 << 620;

   always #5 clk = ~clk;

   assign probe_wall = wall_mode && (probe_y < 9'd224);

   pac_motion_ctrl u_dut (
      .clk(clk), .rst(rst), .move_tick(move_tick),
      .dir_valid(dir_valid), .dir_req(dir_req),
      .probe_wall(probe_wall),
      .ghost1x(g1x), .ghost2x(g2x), .ghost3x(g3x), .ghost4x(g4x),
      .ghost1y(g1y), .ghost2y(g2y), .ghost3y(g3y), .ghost4y(g4y),
      .probe_x(probe_x), .probe_y(probe_y),
      .pac_x(pac_x), .pac_y(pac_y), .state(state),
      .beanmap(beanmap), .score(score), .over(over), .busy(busy)
   );

   pac_motion_ctrl #(.INIT_BEANS(ONE_BEAN)) u_dut2 (
      .clk(clk), .rst(rst), .move_tick(tick2),
      .dir_valid(zero), .dir_req(2'b00),
      .probe_wall(zero),
      .ghost1x(g1x), .ghost2x(g2x), .ghost3x(g3x), .ghost4x(g4x),
      .ghost1y(g1y), .ghost2y(g2y), .ghost3y(g3y), .ghost4y(g4y),
      .probe_x(probe_x2), .probe_y(probe_y2),
      .pac_x(pac_x2), .pac_y(pac_y2), .state(state2),
      .beanmap(beanmap2), .score(score2), .over(over2), .busy(busy2)
   );

   typedef struct {
      int x;
      int y;
      int st;
      int score;
      int nbeans;
   } exp_t;

   exp_t sbq [$];
   exp_t e_mon;
   int total = 0;
   int bad = 0;

   int m_x, m_y, m_st, m_pend, m_score;
   bit m_over;
   bit [1199:0] m_beans;
   logic prev_busy = 1'b0;

   task automatic chk(input string tag, input int got, input int exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   function automatic bit blk(int x, int y, int d);
      int cx, cy;
      for (int c = 0; c < 2; c++) begin
         case (d)
            2: begin cx = x + 33;     cy = y + 31 * c; end
            3: begin cx = x - 2;      cy = y + 31 * c; end
            0: begin cx = x + 31 * c; cy = y + 33;     end
            default: begin cx = x + 31 * c; cy = y - 2; end
         endcase
         if (cx < 0 || cx > 639 || cy < 0 || cy > 479) return 1;
         if (wall_mode && cy < 224) return 1;
      end
      return 0;
   endfunction

   // apply one accepted tick to the model; returns latency class
   function automatic int model_tick();
      int d, idx, lat;
      exp_t e;
      lat = 0;
      d = m_st;
      if (m_over) return -1;
      if (!blk(m_x, m_y, m_pend)) begin
         d = m_pend;
         lat = 4;
      end else if (m_pend != m_st && !blk(m_x, m_y, m_st)) begin
         d = m_st;
         lat = 6;
      end
      if (lat != 0) begin
         case (d)
            0: m_y += 2;
            1: m_y -= 2;
            2: m_x += 2;
            default: m_x -= 2;
         endcase
         m_st = d;
         idx = ((m_y + 16) >> 4) * 40 + ((m_x + 16) >> 4);
         if (idx < 1200 && m_beans[idx]) begin
            m_beans[idx] = 1'b0;
            m_score++;
         end
      end
      e = '{m_x, m_y, m_st, m_score, $countones(m_beans)};
      sbq.push_back(e);
      return lat;
   endfunction

   task automatic do_tick();
      int ox, oy, lat, idle_c;
      ox = m_x;
      oy = m_y;
      lat = model_tick();
      idle_c = (m_pend == m_st) ? 4 : 6;
      @(negedge clk) move_tick = 1'b1;
      @(negedge clk) move_tick = 1'b0;
      for (int c = 2; c <= 8; c++) begin
         @(negedge clk);
         if (lat > 0 && c == lat - 1) chk("lat_before", pac_x, ox);
         if (lat > 0 && c == lat) begin
            chk("lat_x", pac_x, m_x);
            chk("lat_y", pac_y, m_y);
         end
         if (lat <= 0 && c == idle_c) begin
            chk("nomove_busy", busy, 0);
            chk("nomove_x", pac_x, ox);
         end
      end
   endtask

   task automatic set_dir(input logic [1:0] d);
      @(negedge clk);
      dir_valid = 1'b1;
      dir_req = d;
      @(negedge clk);
      dir_valid = 1'b0;
      m_pend = d;
   endtask

   // scoreboard: each return to IDLE retires one expected result
   always @(negedge clk) begin
      if (prev_busy && !busy) begin
         if (sbq.size() == 0) begin
            chk("sb_unexpected", 1, 0);
         end else begin
            e_mon = sbq.pop_front();
            chk("sb_x", pac_x, e_mon.x);
            chk("sb_y", pac_y, e_mon.y);
            chk("sb_state", state, e_mon.st);
            chk("sb_score", score, e_mon.score);
            chk("sb_beans", $countones(beanmap), e_mon.nbeans);
         end
      end
      prev_busy <= busy;
   end

   initial begin
      rst = 1'b1;
      move_tick = 1'b0;
      dir_valid = 1'b0;
      dir_req = 2'b00;
      wall_mode = 1'b0;
      tick2 = 1'b0;
      zero = 1'b0;
      {g1x, g2x, g3x, g4x} = '0;
      {g1y, g2y, g3y, g4y} = '0;
      m_x = 304;
      m_y = 224;
      m_st = 2;
      m_pend = 2;
      m_score = 0;
      m_over = 0;
      m_beans = '1;
      repeat (3) @(negedge clk);
      rst = 1'b0;

      chk("rst_x", pac_x, 304);
      chk("rst_y", pac_y, 224);
      chk("rst_state", state, 2);
      chk("rst_score", score, 0);
      chk("rst_over", over, 0);
      chk("rst_busy", busy, 0);
      chk("rst_probe_x", probe_x, 0);
      chk("rst_probe_y", probe_y, 0);
      chk("rst_beans", $countones(beanmap), 1200);
      chk("rst_beans2", $countones(beanmap2), 1);

      // single-bean instance: eat it, game over follows
      @(negedge clk) tick2 = 1'b1;
      @(negedge clk) tick2 = 1'b0;
      @(negedge clk);
      @(negedge clk);
      chk("b2_over_early", over2, 0);
      @(negedge clk);
      chk("b2_x", pac_x2, 306);
      repeat (4) @(negedge clk);
      chk("b2_score", score2, 1);
      chk("b2_beans", $countones(beanmap2), 0);
      chk("b2_over", over2, 1);
      @(negedge clk) tick2 = 1'b1;
      @(negedge clk) tick2 = 1'b0;
      @(negedge clk);
      chk("b2_no_tick", busy2, 0);
      chk("b2_hold_x", pac_x2, 306);

      // first move straight ahead, eats cell 620
      do_tick();
      chk("t1_bean620", beanmap[620], 0);

      // requested up is walled, continue right
      wall_mode = 1'b1;
      set_dir(2'b01);
      do_tick();
      set_dir(2'b10);
      wall_mode = 1'b0;

      // tick every cycle: only IDLE-cycle ticks are taken
      void'(model_tick());
      void'(model_tick());
      for (int i = 0; i < 10; i++) begin
         @(negedge clk) move_tick = 1'b1;
      end
      @(negedge clk) move_tick = 1'b0;
      for (int i = 0; i < 20 && sbq.size() != 0; i++)
         @(negedge clk);
      chk("burst_x", pac_x, m_x);
      chk("burst_drain", sbq.size(), 0);

      // march to the right screen edge
      while (m_x < 608) do_tick();
      chk("edge_x", pac_x, 608);
      do_tick();
      chk("edge_score", score, m_score);

      // ghost distance exactly HIT_DIST does not collide
      @(negedge clk);
      g2x = 10'd632;
      g2y = 9'd224;
      g4x = 10'd608;
      g4y = 9'd248;
      @(negedge clk);
      @(negedge clk);
      chk("ghost_24", over, 0);
      g1x = 10'd585;
      g1y = 9'd201;
      @(negedge clk);
      chk("ghost_23", over, 1);
      g1x = '0;
      g1y = '0;
      @(negedge clk);
      chk("over_sticky", over, 1);
      m_over = 1;

      // after game over, ticks are ignored
      set_dir(2'b11);
      do_tick();
      chk("over_x", pac_x, 608);
      chk("over_busy", busy, 0);
      chk("sb_left", sbq.size(), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
